fpu_result_queue: RTL

- Sits directly downstream of the FPU.
- Captures each completed FP result (data plus destination register address) on the FPU's one-cycle push pulse.
- Holds results in order in a small FIFO and drains them into the register-file write port on cycles the integer writeback path leaves free.
- Drives FIFO-based back-pressure to the FPU issue logic and per-read-port pending-write flags for hazard detection.

---
 rtl/fpu_result_queue.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fpu_result_queue.sv
// -----------------------------------------------------------------------------
// fpu_result_queue
//
// Result FIFO sitting directly downstream of the FPU. Each completed FP result
// (data plus destination register) is captured on the FPU's one-cycle push
// pulse. Results are drained in order into the register-file write port on
// cycles the integer writeback path leaves free. The block also produces
// back-pressure for the FPU issue logic and pending-write flags for hazard
// detection on the two decode-stage read ports.
//
// Ports:
//   CLK         system clock, rising-edge active
//   Reset       asynchronous active-low reset; all entries are discarded
//   PushIn      one-cycle pulse: FPU result valid this cycle
//   PushData    FPU result data
//   PushWA3     FPU destination register address
//   WBFree      register-file write port is free this cycle
//   RA1, RA2    decode-stage source register addresses
//   WE3         register-file write enable (head entry drains this cycle)
//   WD3, FWA3   head entry data / destination address
//   Full        Count == DEPTH
//   AlmostFull  Count >= DEPTH-1; FPU Start must be held off while high
//   Empty       Count == 0
//   Count       number of occupied entries
//   Pending1/2  a queued or incoming result targets RA1 / RA2
//   Overflow    sticky: a push arrived while full with no pop and was dropped
// -----------------------------------------------------------------------------
module fpu_result_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     PushIn,
  input  logic [DATA_W-1:0]        PushData,
  input  logic [ADDR_W-1:0]        PushWA3,
  input  logic                     WBFree,
  input  logic [ADDR_W-1:0]        RA1,
  input  logic [ADDR_W-1:0]        RA2,
  output logic                     WE3,
  output logic [DATA_W-1:0]        WD3,
  output logic [ADDR_W-1:0]        FWA3,
  output logic                     Full,
  output logic                     AlmostFull,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Pending1,
  output logic                     Pending2,
  output logic                     Overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_wa   [DEPTH];

  logic [PTR_W-1:0]  rp;
  logic [PTR_W-1:0]  wp;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic              pop;
  logic              push;

  // Distance of each slot from the head; a slot is live when that distance is
  // below the occupancy count. Pointer arithmetic wraps naturally because
  // DEPTH is a power of two.
  logic [PTR_W-1:0]  offset [DEPTH];
  logic [DEPTH-1:0]  occupied;

  // Status flags come only from the registered count, never from PushIn.
  assign Empty      = (count_q == '0);
  assign Full       = (count_q == CNT_W'(DEPTH));
  assign AlmostFull = (count_q >= CNT_W'(DEPTH - 1));
  assign Count      = count_q;
  assign Overflow   = overflow_q;

  assign WE3  = ~Empty & WBFree;
  assign pop  = WE3;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = PushIn & (~Full | pop);

  // No fall-through: the head is always a stored entry.
  assign WD3  = mem_data[rp];
  assign FWA3 = mem_wa[rp];

  always_ff @(posedge CLK or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!Reset) begin
      rp         <= '0;
      wp         <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop)  rp <= rp + PTR_W'(1);
      if (push) wp <= wp + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      if (PushIn && !push) overflow_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; only slots between RP and WP are
  // ever observed as valid, so clearing it would cost flops for no benefit.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wp] <= PushData;
      mem_wa[wp]   <= PushWA3;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset[i]   = PTR_W'(i) - rp;
      occupied[i] = ({1'b0, offset[i]} < count_q);
    end
  end

  // An entry popped this cycle still counts: the register file is written at
  // the edge, so a same-cycle read of that register would still be stale.
  always_comb begin
    Pending1 = PushIn & (PushWA3 == RA1);
    Pending2 = PushIn & (PushWA3 == RA2);
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && (mem_wa[i] == RA1)) Pending1 = 1'b1;
      if (occupied[i] && (mem_wa[i] == RA2)) Pending2 = 1'b1;
    end
  end

endmodule
